goldschmidt_ctrl: RTL and testbench

Sequencer for the Goldschmidt divider datapath. It drives the datapath's register-load and mux-select controls (load_regN, load_regD, sel_ND_mux, sel_K_mux). Its output sequence is: an initial IA*D / IA*N pair, then ITERS K*D / K*N refinement pairs. It provides a start/busy/done handshake to the surrounding FPU logic and sits directly beside the datapath instance.

---
 rtl/goldschmidt_ctrl.sv | 117 +++++++++++
 tb/tb_goldschmidt_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_ctrl.sv
// Control sequencer for the Goldschmidt divider datapath: issues the IA*D/IA*N
// seed pair, then ITERS K*D/K*N refinement pairs, with a start/busy/done handshake.
module goldschmidt_ctrl #(
   parameter int ITERS = 4,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          clear,
   output logic          busy,
   output logic          done,
   output logic          load_regN,
   output logic          load_regD,
   output logic [1:0]    sel_ND_mux,
   output logic          sel_K_mux,
   output logic [CW-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT_D = 3'd1,
      INIT_N = 3'd2,
      ITER_D = 3'd3,
      ITER_N = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [CW-1:0] LAST_PAIR = CW'(ITERS);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         iter_cnt <= '0;
      end else begin
         state    <= state_nxt;
         iter_cnt <= cnt_nxt;
      end
   end

   // clear overrides everything; unused encodings fall back to IDLE
   always_comb begin
      state_nxt = state;
      cnt_nxt   = iter_cnt;
      if (clear) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nxt = '0;
               if (start) state_nxt = INIT_D;
            end
            INIT_D: state_nxt = INIT_N;
            INIT_N: begin
               state_nxt = ITER_D;
               cnt_nxt   = CW'(1);
            end
            ITER_D: state_nxt = ITER_N;
            ITER_N: begin
               if (iter_cnt == LAST_PAIR) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ITER_D;
                  cnt_nxt   = iter_cnt + CW'(1);
               end
            end
            DONE: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      load_regN  = 1'b0;
      load_regD  = 1'b0;
      sel_ND_mux = 2'b00;
      sel_K_mux  = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         INIT_D: begin
            load_regD = 1'b1;
            busy      = 1'b1;
         end
         INIT_N: begin
            load_regN  = 1'b1;
            sel_ND_mux = 2'b01;
            busy       = 1'b1;
         end
         ITER_D: begin
            load_regD  = 1'b1;
            sel_ND_mux = 2'b10;
            sel_K_mux  = 1'b0;
            busy       = 1'b1;
         end
         ITER_N: begin
            load_regN  = 1'b1;
            sel_ND_mux = 2'b11;
            sel_K_mux  = 1'b0;
            busy       = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Scoreboard bench for goldschmidt_ctrl: stimulus queues expected per-cycle control
// words, monitors pop them whenever a sequencer is busy or signalling done.
module tb_goldschmidt_ctrl;

   typedef struct {
      logic [10:0] v;
      int          cyc;
   } rec_t;

   logic       clock = 1'b0;
   logic       resetN, start, start1, clear;
   logic       busy, done, loadN, loadD, selK;
   logic [1:0] selND;
   logic [3:0] iterCnt;
   logic       busy1, done1, loadN1, loadD1, selK1;
   logic [1:0] selND1;
   logic [3:0] iterCnt1;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   base;
   rec_t q0[$];
   rec_t q1[$];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   goldschmidt_ctrl #(.ITERS(4), .CW(4)) dut (
      .clk(clock), .reset(resetN), .start(start), .clear(clear),
      .busy(busy), .done(done), .load_regN(loadN), .load_regD(loadD),
      .sel_ND_mux(selND), .sel_K_mux(selK), .iter_cnt(iterCnt)
   );

   goldschmidt_ctrl #(.ITERS(1), .CW(4)) dut1 (
      .clk(clock), .reset(resetN), .start(start1), .clear(clear),
      .busy(busy1), .done(done1), .load_regN(loadN1), .load_regD(loadD1),
      .sel_ND_mux(selND1), .sel_K_mux(selK1), .iter_cnt(iterCnt1)
   );

   wire [10:0] act0 = {loadN, loadD, selND, selK, busy, done, iterCnt};
   wire [10:0] act1 = {loadN1, loadD1, selND1, selK1, busy1, done1, iterCnt1};

   // Control word {load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, iter_cnt}
   function automatic logic [10:0] rowOf(input int st, input int cnt);
      logic [3:0] c;
      c = cnt[3:0];
      case (st)
         1:       rowOf = {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, c};
         2:       rowOf = {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, c};
         3:       rowOf = {1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, c};
         4:       rowOf = {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, c};
         5:       rowOf = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, c};
         default: rowOf = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, c};
      endcase
   endfunction

   // Position p of a run: 1 INIT_D, 2 INIT_N, odd/even ITER_D/ITER_N, last DONE
   task automatic pushRun(input int which, input int iters, input int nRecs, input int startCyc);
      rec_t r;
      int   st, cnt;
      for (int p = 1; p <= nRecs; p++) begin
         if (p == 1) begin st = 1; cnt = 0; end
         else if (p == 2) begin st = 2; cnt = 0; end
         else if (p <= 2 + 2 * iters) begin
            st  = (p % 2 == 1) ? 3 : 4;
            cnt = (p - 1) / 2;
         end else begin st = 5; cnt = iters; end
         r.v   = rowOf(st, cnt);
         r.cyc = startCyc + p;
         if (which == 0) q0.push_back(r);
         else            q1.push_back(r);
      end
   endtask

   task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic checkRec(input string name, input logic [10:0] act, input rec_t r);
      vectors++;
      if (act !== r.v || cyc != r.cyc) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                  name, act, cyc, r.v, r.cyc);
      end
   endtask

   task automatic checkEmpty(input string name);
      vectors++;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s: pending expected words %0d/%0d, expected 0/0",
                  name, q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic applyStimulus(input logic s, input logic s1, input logic c);
      start  = s;
      start1 = s1;
      clear  = c;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Monitors: every busy/done cycle must match the next queued word and its cycle
   always @(negedge clock) begin
      if (busy || done) begin
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut_unexpected: got %b at cycle %0d, expected no activity", act0, cyc);
         end else begin
            checkRec("dut_seq", act0, q0.pop_front());
         end
      end
      if (busy1 || done1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut1_unexpected: got %b at cycle %0d, expected no activity", act1, cyc);
         end else begin
            checkRec("dut1_seq", act1, q1.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      vectors++;
      if ((loadN && loadD) || (busy && done) || (loadN1 && loadD1) || (busy1 && done1)) begin
         miscompares++;
         $display("[TB] FAIL invariant: loads %b%b/%b%b busy_done %b%b/%b%b, expected no overlap",
                  loadN, loadD, loadN1, loadD1, busy, done, busy1, done1);
      end
   end

   initial begin
      resetN = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_state", act0, rowOf(0, 0));
      checkOutput("reset_state1", act1, rowOf(0, 0));
      tick(2);
      resetN = 1'b1;
      tick(1);

      // Single run, start pulsed one cycle after reset release
      applyStimulus(1'b1, 1'b0, 1'b0);
      pushRun(0, 4, 11, cyc);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(14);
      checkOutput("idle_after_run", act0, rowOf(0, 0));
      checkEmpty("single_run");

      // start held high: second INIT_D two cycles after done
      applyStimulus(1'b1, 1'b0, 1'b0);
      base = cyc;
      pushRun(0, 4, 11, base);
      pushRun(0, 4, 11, base + 12);
      tick(20);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(10);
      checkEmpty("back_to_back");

      // Async reset at the falling edge of cycle 5 (ITER_D of pair 2)
      applyStimulus(1'b1, 1'b0, 1'b0);
      pushRun(0, 4, 5, cyc);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(4);
      @(negedge clock);
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("async_reset", act0, rowOf(0, 0));
      tick(2);
      resetN = 1'b1;
      tick(6);
      checkOutput("post_reset_idle", act0, rowOf(0, 0));
      checkEmpty("reset_no_done");

      // clear during ITER_N of pair 2, then clear beats start
      applyStimulus(1'b1, 1'b0, 1'b0);
      pushRun(0, 4, 6, cyc);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(5);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("clear_idle", act0, rowOf(0, 0));
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick(2);
      checkOutput("clear_beats_start", act0, rowOf(0, 0));
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      checkEmpty("clear_no_done");

      // Fresh run after an abort must be complete
      applyStimulus(1'b1, 1'b0, 1'b0);
      pushRun(0, 4, 11, cyc);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(14);
      checkEmpty("run_after_clear");

      // ITERS=1 instance: 00,01,10,11 then done
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushRun(1, 1, 5, cyc);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(8);
      checkOutput("iters1_idle", act1, rowOf(0, 0));
      checkEmpty("iters1_run");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
